regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Register-file write-back arbiter with a 2-entry long-latency
//            result FIFO and a destination scoreboard (pending vector).
// Config   : WB_EARLY_RELEASE_EN - clear busy in the cycle the head pops
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_wen,
   input  logic [4:0]  pipe_addr,
   input  logic [31:0] pipe_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_addr,
   input  logic [31:0] lsu_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_addr,
   input  logic [4:0]  chk_addr1,
   input  logic [4:0]  chk_addr2,
   output logic        busy1,
   output logic        busy2,
   output logic        w_en,
   output logic [4:0]  w_addr,
   output logic [31:0] w_data
);

   logic [4:0]  fifo_addr_q [2];
   logic [31:0] fifo_data_q [2];
   logic        rd_ptr_q;
   logic        wr_ptr_q;
   logic [1:0]  count_q;
   logic [1:0]  count_d;
   logic [31:0] pending_q;
   logic [31:0] pending_d;
   logic        w_en_q;
   logic        w_en_d;
   logic [4:0]  w_addr_q;
   logic [4:0]  w_addr_d;
   logic [31:0] w_data_q;
   logic [31:0] w_data_d;
   logic        accept;
   logic        pop;
   logic [4:0]  head_addr;
   logic [31:0] head_data;
   logic        release1;
   logic        release2;

   assign lsu_ready = (count_q != 2'd2);
   assign accept    = lsu_valid & lsu_ready;
   // The pipeline always wins the write port; the FIFO drains only in idle slots.
   assign pop       = ~pipe_wen & (count_q != 2'd0);
   assign head_addr = fifo_addr_q[rd_ptr_q];
   assign head_data = fifo_data_q[rd_ptr_q];

   always_comb begin
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      if (pipe_wen) begin
         if (pipe_addr != 5'd0) begin
            w_en_d   = 1'b1;
            w_addr_d = pipe_addr;
            w_data_d = pipe_data;
         end
      end else if (pop && (head_addr != 5'd0)) begin
         w_en_d   = 1'b1;
         w_addr_d = head_addr;
         w_data_d = head_data;
      end
   end

   // Set is applied after clear so a same-edge reservation survives the pop.
   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[head_addr] = 1'b0;
      end
      if (issue_valid && (issue_addr != 5'd0)) begin
         pending_d[issue_addr] = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         pending_q <= 32'd0;
         w_en_q    <= 1'b0;
         w_addr_q  <= 5'd0;
         w_data_q  <= 32'd0;
      end else begin
         if (accept) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q   <= count_d;
         pending_q <= pending_d;
         w_en_q    <= w_en_d;
         w_addr_q  <= w_addr_d;
         w_data_q  <= w_data_d;
      end
   end

   // Payload storage needs no reset: occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_addr_q[wr_ptr_q] <= lsu_addr;
         fifo_data_q[wr_ptr_q] <= lsu_data;
      end
   end

`ifdef WB_EARLY_RELEASE_EN
   assign release1 = pop && (head_addr == chk_addr1);
   assign release2 = pop && (head_addr == chk_addr2);
`else
   assign release1 = 1'b0;
   assign release2 = 1'b0;
`endif

   assign busy1  = (chk_addr1 != 5'd0) & pending_q[chk_addr1] & ~release1;
   assign busy2  = (chk_addr2 != 5'd0) & pending_q[chk_addr2] & ~release2;

   assign w_en   = w_en_q;
   assign w_addr = w_addr_q;
   assign w_data = w_data_q;

endmodule

`default_nettype wire
